joy_db15_tx: RTL and testbench
==============================

JOY_DB15_TX -- requirements
Module: joy_db15_tx

Device-side end of the DB15 serial joystick link. The host drives joy_load and joy_clk and samples joy_data. This block emulates the 74HC165 chain and presents two players' buttons as one 32-bit active-low frame.

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchroniser flops on joy_load and joy_clk, legal range 2..4.
REQ-002 SHALL have port clk, input, 1: system clock, 24-50 MHz.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset, released synchronously by the integrating level.
REQ-004 SHALL have port joystick1, input, 16: player-1 buttons, active high, bit map LS FEDCBAUDLR.
REQ-005 SHALL have port joystick2, input, 16: player-2 buttons, active high, same bit map.
REQ-006 SHALL have port joy_load, input, 1: host parallel-load strobe, active low, asynchronous to clk.
REQ-007 SHALL have port joy_clk, input, 1: host shift clock, shifting on the rising edge, asynchronous to clk.
REQ-008 SHALL have port joy_data, output, 1: serial data, active low, registered.
REQ-009 SHALL have port frame_done, output, 1: one-clk pulse on the 32nd accepted shift.
REQ-010 SHALL have port overrun, output, 1: sticky flag, set when a shift arrives after the frame is exhausted.
REQ-011 SHALL have port bit_cnt, output, 6: shifts accepted since the last load, saturating at 32.

Function
REQ-012 SHALL pass joy_load and joy_clk through SYNC_STAGES flops each; all further logic SHALL use only the synchronised copies (ld_s, ck_s).
REQ-013 SHALL hold a 32-bit shift register sr, frame = {~joystick2, ~joystick1}.
REQ-014 While ld_s=0, SHALL reload sr from the frame every clk and hold bit_cnt at 0.
REQ-015 SHALL accept a shift on each ck_s 0->1 transition while ld_s=1: sr <= {1'b1, sr[31:1]}, and bit_cnt increments.
REQ-016 SHALL register joy_data = sr[0], so joystick1[0] is presented first and joystick2[15] last.
REQ-017 Latency SHALL be exactly SYNC_STAGES+2 clk cycles from a joy_clk pin rise to the joy_data change.
REQ-018 Latency SHALL be exactly SYNC_STAGES+2 clk cycles from a joy_load pin fall to frame bit 0 appearing on joy_data.
REQ-019 If a ck_s rise coincides with ld_s=0, load SHALL win; no shift is counted and overrun is unchanged.
REQ-020 A load mid-frame SHALL abort the frame: sr is reloaded, bit_cnt=0, and no frame_done is issued.
REQ-021 The shift that takes bit_cnt from 31 to 32 SHALL pulse frame_done for one clk.
REQ-022 Shifts with bit_cnt=32 SHALL keep bit_cnt at 32, shift 1s (joy_data=1), and set overrun.
REQ-023 overrun SHALL clear on the first clk with ld_s=0.
REQ-024 joystick inputs SHALL be sampled only during load; changes during shifting SHALL NOT alter sr.

Reset
REQ-025 On reset_n=0, asynchronously: sr = all 1s, joy_data=1, bit_cnt=0, frame_done=0, overrun=0.
REQ-026 Synchroniser flops SHALL reset to 1 (idle level), so a high joy_clk at release produces no edge.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release, no output SHALL change until the next load or accepted edge.

Configuration
REQ-028 Macro JOY_TX_GLITCH_FILTER_EN defined: a ck_s transition SHALL be accepted only after ck_s holds the new level for 3 consecutive clks.
REQ-029 With JOY_TX_GLITCH_FILTER_EN defined, shift latency SHALL become SYNC_STAGES+4, and ck_s pulses shorter than 3 clks SHALL be ignored.
REQ-030 Macro JOY_TX_GLITCH_FILTER_EN undefined: no filter, latencies exactly as REQ-017 and REQ-018.

Verification
REQ-031 Load-and-read: j1=16'h0001, j2=16'h8000, load pulse, then 32 clean clocks -> joy_data reads 0,1×30,0; frame_done pulses once; bit_cnt=32.
REQ-032 Overrun: after a full frame, 2 more clocks -> joy_data=1, overrun=1, bit_cnt=32; next load -> overrun=0, bit_cnt=0.
REQ-033 Abort: load, 10 clocks, load again with j1=16'hFFFF -> bit_cnt=0, joy_data=0, no frame_done.
REQ-034 Coincidence: joy_clk rises in the same cycle ld_s=0 -> bit_cnt stays 0 and sr is unchanged from the frame.
REQ-035 Reset mid-frame: reset_n low after 5 shifts -> joy_data=1 and bit_cnt=0 immediately; joy_clk high at release -> no shift counted.
REQ-036 Filter: with JOY_TX_GLITCH_FILTER_EN defined, a 2-clk joy_clk pulse -> ignored; a 5-clk pulse -> 1 shift, seen on joy_data at SYNC_STAGES+4 clks.

Source files
------------

// File: rtl/joy_db15_if.sv
// joy_db15_if: DB15 joystick link pins (host-driven load/clock, device-driven data)
interface joy_db15_if;
  logic joy_load;
  logic joy_clk;
  logic joy_data;
  modport master (output joy_load, output joy_clk, input joy_data);
  modport slave (input joy_load, input joy_clk, output joy_data);
endinterface

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: device-side 74HC165-chain emulation serialising two players' buttons as a 32-bit active-low frame
// Ports: clk/reset_n (async active-low); joystick1/joystick2 active-high buttons;
//   link (slave): joy_load, joy_clk from host, registered joy_data to host;
//   frame_done one-clk pulse on 32nd shift; overrun sticky until next load; bit_cnt shifts since load (saturates at 32).
// Optional: define JOY_TX_GLITCH_FILTER_EN to require joy_clk to hold a level for 3 clks before it counts.
module joy_db15_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  joy_db15_if.slave   link,
  output logic        frame_done,
  output logic        overrun,
  output logic [5:0]  bit_cnt
);
  logic [SYNC_STAGES-1:0] ld_sync, ck_sync;
  logic [31:0] sr;
  logic ld_s, ck_s, shift;
  assign ld_s = ld_sync[SYNC_STAGES-1];
  assign ck_s = ck_sync[SYNC_STAGES-1];
  // Idle level is high so a host clock already high at release is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ld_sync <= '1;
      ck_sync <= '1;
    end else begin
      ld_sync <= {ld_sync[SYNC_STAGES-2:0], link.joy_load};
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], link.joy_clk};
    end
`ifdef JOY_TX_GLITCH_FILTER_EN
  logic ck_f;
  logic [1:0] hold;
  // A new level is adopted on the third consecutive clk it is seen; the rise is accepted on that same clk.
  assign shift = ld_s & ck_s & ~ck_f & (hold == 2'd2);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ck_f <= 1'b1;
      hold <= 2'd0;
    end else if (ck_s == ck_f) begin
      hold <= 2'd0;
    end else if (hold == 2'd2) begin
      ck_f <= ck_s;
      hold <= 2'd0;
    end else begin
      hold <= hold + 2'd1;
    end
`else
  logic ck_q;
  assign shift = ld_s & ck_s & ~ck_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ck_q <= 1'b1;
    else ck_q <= ck_s;
`endif
  // Load has priority over a coincident shift; shifts past the frame end feed 1s and flag overrun.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sr <= '1;
      bit_cnt <= 6'd0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
      link.joy_data <= 1'b1;
    end else begin
      link.joy_data <= sr[0];
      frame_done <= shift && bit_cnt == 6'd31;
      if (!ld_s) begin
        sr <= {~joystick2, ~joystick1};
        bit_cnt <= 6'd0;
        overrun <= 1'b0;
      end else if (shift) begin
        sr <= {1'b1, sr[31:1]};
        bit_cnt <= bit_cnt == 6'd32 ? 6'd32 : bit_cnt + 6'd1;
        overrun <= overrun | (bit_cnt == 6'd32);
      end
    end
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: directed self-checking bench for joy_db15_tx
module tb_joy_db15_tx;
  localparam int S = 2;
`ifdef JOY_TX_GLITCH_FILTER_EN
  localparam int LCK = S + 4;
`else
  localparam int LCK = S + 2;
`endif
  logic clk = 1'b0;
  logic reset_n;
  logic [15:0] j1, j2;
  logic frame_done, overrun;
  logic [5:0] bit_cnt;
  int n_tests = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  joy_db15_if link ();
  joy_db15_tx #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .joystick1(j1), .joystick2(j2),
    .link(link), .frame_done(frame_done), .overrun(overrun), .bit_cnt(bit_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load();
    link.joy_load = 1'b0;
    step(4);
    link.joy_load = 1'b1;
    step(4);
  endtask
  task automatic shift1();
    link.joy_clk = 1'b1;
    step(4);
    link.joy_clk = 1'b0;
    step(4);
  endtask
  initial begin
    reset_n = 1'b0;
    link.joy_load = 1'b1;
    link.joy_clk = 1'b0;
    j1 = 16'h0001;
    j2 = 16'h8000;
    step(3);
    chk("rst_data", link.joy_data, 1);
    chk("rst_cnt", bit_cnt, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    step(4);
    chk("idle_cnt", bit_cnt, 0);
    load();
    chk("frm_bit0", link.joy_data, 0);
    chk("frm_cnt0", bit_cnt, 0);
    for (int k = 1; k < 32; k++) begin
      shift1();
      chk($sformatf("frm_bit%0d", k), link.joy_data, (k == 31) ? 0 : 1);
    end
    chk("frm_fd_pre", fd_cnt, 0);
    shift1();
    chk("frm_cnt32", bit_cnt, 32);
    chk("frm_fd", fd_cnt, 1);
    chk("frm_ovr0", overrun, 0);
    shift1();
    shift1();
    chk("ovr_data", link.joy_data, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_cnt", bit_cnt, 32);
    chk("ovr_fd", fd_cnt, 1);
    load();
    chk("ovr_clr", overrun, 0);
    chk("ovr_cnt0", bit_cnt, 0);
    repeat (10) shift1();
    chk("abt_cnt10", bit_cnt, 10);
    chk("abt_bit10", link.joy_data, 1);
    j1 = 16'hFFFF;
    step(4);
    chk("abt_nosample", link.joy_data, 1);
    load();
    chk("abt_cnt0", bit_cnt, 0);
    chk("abt_data", link.joy_data, 0);
    chk("abt_fd", fd_cnt, 1);
    j1 = 16'h0002;
    j2 = 16'h0000;
    link.joy_load = 1'b0;
    link.joy_clk = 1'b1;
    step(4);
    link.joy_load = 1'b1;
    step(4);
    chk("coin_cnt", bit_cnt, 0);
    chk("coin_data", link.joy_data, 1);
    chk("coin_ovr", overrun, 0);
    link.joy_clk = 1'b0;
    step(4);
    chk("coin_cnt_after", bit_cnt, 0);
    j1 = 16'h0020;
    load();
    repeat (5) shift1();
    chk("rmf_cnt5", bit_cnt, 5);
    chk("rmf_bit5", link.joy_data, 0);
    link.joy_clk = 1'b1;
    step(1);
    #2 reset_n = 1'b0;
    #1;
    chk("rmf_async_data", link.joy_data, 1);
    chk("rmf_async_cnt", bit_cnt, 0);
    step(3);
    reset_n = 1'b1;
    step(8);
    chk("rmf_rel_cnt", bit_cnt, 0);
    chk("rmf_rel_data", link.joy_data, 1);
    chk("rmf_rel_fd", fd_cnt, 1);
    link.joy_clk = 1'b0;
    step(4);
    j1 = 16'h0001;
    load();
    chk("lat_bit0", link.joy_data, 0);
    link.joy_clk = 1'b1;
    step(LCK - 1);
    chk("lat_ck_early", link.joy_data, 0);
    step(1);
    chk("lat_ck_exact", link.joy_data, 1);
    link.joy_clk = 1'b0;
    step(4);
    link.joy_load = 1'b0;
    step(S + 1);
    chk("lat_ld_early", link.joy_data, 1);
    step(1);
    chk("lat_ld_exact", link.joy_data, 0);
    link.joy_load = 1'b1;
    step(4);
`ifdef JOY_TX_GLITCH_FILTER_EN
    link.joy_clk = 1'b1;
    step(2);
    link.joy_clk = 1'b0;
    step(6);
    chk("flt_short_cnt", bit_cnt, 0);
    chk("flt_short_data", link.joy_data, 0);
    link.joy_clk = 1'b1;
    step(S + 3);
    chk("flt_long_early", link.joy_data, 0);
    step(1);
    chk("flt_long_exact", link.joy_data, 1);
    step(1);
    link.joy_clk = 1'b0;
    step(4);
    chk("flt_long_cnt", bit_cnt, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
